imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts a full 32-bit RISC-V instruction plus a sideband tag (e.g. PC). Produces the sign- or zero-extended immediate at XLEN width.
- Covers I, S, B, J, U and shift-amount formats. The format comes from either an external select or internal opcode decode.
- Registered output behind a 2-entry skid buffer with valid/ready handshakes and flush, so decode can stall without losing instructions.

Parameters:
- XLEN, 32: output width; legal values 32 or 64.
- EXT_SRC, 0: 1 = format taken from in_imm_src; 0 = format decoded from instr[6:0]/funct3.
- TAG_W, 32: width of the sideband tag carried alongside each instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  drop all held and incoming entries.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept.
- in_instr  input  32  instruction word.
- in_imm_src  input  3  format select; used only when EXT_SRC=1.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  extended immediate.
- out_illegal  output  1  unsupported format or opcode.
- out_tag  output  TAG_W  tag of the entry at the output.

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, out_imm=0, out_illegal=0, out_tag=0, skid buffer empty.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after.
- Format codes:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25],instr[11:7]}).
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 011 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 100 U: sext({instr[31:12],12'b0}); sign extension matters only when XLEN=64.
  - 101 SHAMT: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64). funct7/funct6 bits are ignored.
  - 110, 111: imm=0, illegal=1.
- Internal decode (EXT_SRC=0):
  - 0000011 load, 1100111 JALR → I.
  - 0010011 → SHAMT if funct3 is 001 or 101, else I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 0011011 → SHAMT with 5-bit shamt if funct3 is 001/101, else I. Only when XLEN=64; illegal when XLEN=32.
  - Any other opcode → imm=0, illegal=1.
- Latency: 1 cycle. An input accepted at edge N is presented on out_* after edge N.
- Handshakes:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
- Skid buffer: output register plus one skid entry.
  - in_ready = !skid_full; registered, never combinational from out_ready.
  - Output stalled, input accepted → the entry goes to skid; in_ready drops next cycle.
  - Output consumed while skid is full → the skid entry moves to the output register; in_ready rises next cycle.
  - Simultaneous output transfer and input transfer with skid empty → the new entry replaces the output register directly.
  - Strict FIFO order; no entry duplicated or lost.
- Flush (synchronous):
  - Clears out_valid and skid; the input offered that cycle is dropped.
  - out_valid=0 and in_ready=1 after the edge.
  - Flush takes priority over a simultaneous in/out transfer.
  - out_imm/out_tag data may retain old values; only valid is cleared.
- rst asserted mid-stall: identical to the reset values above, buffered entries discarded.
- All extension arithmetic is pure bit selection/replication; no adders.

Test Plan:
- XLEN=32, EXT_SRC=0, out_ready=1:
  - 0xFFF00093 (addi x1,x0,-1) → out_imm 0xFFFFFFFF.
  - 0x00112623 (sw) → 0x0000000C.
  - 0xFE000EE3 (beq -4) → 0xFFFFFFFC.
  - 0x001000EF (jal +2048) → 0x00000800.
  - 0x123452B7 (lui) → 0x12345000.
  - Each result appears exactly one cycle after acceptance, with matching tag.
- Shifts and illegal opcodes:
  - 0x01F09093 (slli 31) → 0x0000001F.
  - 0x41F0D093 (srai 31) → 0x0000001F.
  - 0x0000007F → out_illegal=1, imm 0.
  - XLEN=32, 0x0010809B (opcode 0011011) → illegal=1.
- XLEN=64: 0x800002B7 (lui) → 0xFFFFFFFF80000000; 0x03F09093 (slli 63) → 0x3F.
- Backpressure:
  - Back-to-back inputs tags 1,2,3 with out_ready low for 3 cycles.
  - Required: in_ready falls after tag 2; tag 3 is held off.
  - On out_ready=1, tags 1,2,3 emerge in order, no gaps or duplicates.
- Flush while skid is full and in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed tags never appear at the output.
- rst pulse while out_valid=1 and stalled → all outputs zero, skid empty; a new input afterwards completes normally.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a registered output and a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int EXT_SRC = 0,
  parameter int TAG_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  logic [2:0]      w_fmt;
  logic            w_sh5;
  logic            w_is_sh;
  logic [5:0]      w_sh;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_acc;
  logic            w_pop;
  logic            r_ov, r_oill, r_sv, r_sill;
  logic [XLEN-1:0] r_oimm, r_simm;
  logic [TAG_W-1:0] r_otag, r_stag;
  assign w_is_sh = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);
  always_comb begin
    w_fmt = 3'b111;
    w_sh5 = 1'b0;
    if (EXT_SRC != 0) w_fmt = in_imm_src;
    else
      case (in_instr[6:0])
        7'b0000011, 7'b1100111: w_fmt = 3'b000;
        7'b0010011:             w_fmt = w_is_sh ? 3'b101 : 3'b000;
        7'b0100011:             w_fmt = 3'b001;
        7'b1100011:             w_fmt = 3'b010;
        7'b1101111:             w_fmt = 3'b011;
        7'b0110111, 7'b0010111: w_fmt = 3'b100;
        7'b0011011: begin
          w_fmt = (XLEN == 64) ? (w_is_sh ? 3'b101 : 3'b000) : 3'b111;
          w_sh5 = 1'b1;
        end
        default:                w_fmt = 3'b111;
      endcase
  end
  // word-sized shifts (RV64 *W ops) keep a 5-bit shamt even at XLEN=64
  assign w_sh = (XLEN == 64 && !w_sh5) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (w_fmt)
      3'b000:  w_imm = XLEN'($signed(in_instr[31:20]));
      3'b001:  w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b010:  w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      3'b011:  w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      3'b100:  w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'b101:  w_imm = XLEN'(w_sh);
      default: w_ill = 1'b1;
    endcase
  end
  assign in_ready    = !r_sv && !rst;
  assign w_acc       = in_valid && in_ready;
  assign w_pop       = r_ov && out_ready;
  assign out_valid   = r_ov;
  assign out_imm     = r_oimm;
  assign out_illegal = r_oill;
  assign out_tag     = r_otag;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov   <= 1'b0;
      r_oill <= 1'b0;
      r_oimm <= '0;
      r_otag <= '0;
      r_sv   <= 1'b0;
      r_sill <= 1'b0;
      r_simm <= '0;
      r_stag <= '0;
    end else if (flush) begin
      r_ov <= 1'b0;
      r_sv <= 1'b0;
    end else if (r_sv) begin
      if (w_pop) begin
        r_oimm <= r_simm;
        r_oill <= r_sill;
        r_otag <= r_stag;
        r_sv   <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_ov || w_pop) begin
        r_oimm <= w_imm;
        r_oill <= w_ill;
        r_otag <= in_tag;
        r_ov   <= 1'b1;
      end else begin
        r_simm <= w_imm;
        r_sill <= w_ill;
        r_stag <= in_tag;
        r_sv   <= 1'b1;
      end
    end else if (w_pop) r_ov <= 1'b0;
  end
endmodule
